// File: rtl/updown_pkg.sv
// Shared types and default parameters for the up/down command generator.
package updown_pkg;

  // Default timing parameters.
  localparam int unsigned DefDebounceCycles = 4;
  localparam int unsigned DefRepeatDelay    = 16;
  localparam int unsigned DefRepeatRate     = 4;

  // Command FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StUpHeld,
    StDownHeld,
    StLockout
  } state_e;

  // Larger of two limits, used to size a counter shared by two reload values.
  function automatic int unsigned max_limit(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a run-length debouncer for one raw button.
module btn_debounce
  import updown_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q;
  logic [CntW-1:0] cnt_q;

  assign level = level_q;

  // Synchronize, then accept a new level only after a full run of differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q >= CntLast) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/updown_cmd_gen.sv
// Converts two raw buttons into one-cycle up/down counter commands.
// Optional auto-repeat while a button is held: define UPDOWN_AUTOREPEAT_EN.
module updown_cmd_gen
  import updown_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_RATE     = DefRepeatRate
) (
  input  logic clk,
  input  logic reset,
  input  logic up_btn,
  input  logic down_btn,
  output logic up,
  output logic down,
  output logic active
);

  // Elaboration-time parameter legality checks.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 2) begin : g_bad_delay
    $error("REPEAT_DELAY must be >= 2");
  end
  if (REPEAT_RATE < 2) begin : g_bad_rate
    $error("REPEAT_RATE must be >= 2");
  end

  logic   up_lvl, dn_lvl;
  logic   up_prev_q, dn_prev_q;
  logic   up_rise, dn_rise;
  state_e state_q;
  logic   up_q, down_q, active_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_up_db (
    .clk  (clk),
    .reset(reset),
    .btn  (up_btn),
    .level(up_lvl)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dn_db (
    .clk  (clk),
    .reset(reset),
    .btn  (down_btn),
    .level(dn_lvl)
  );

  assign up_rise = up_lvl & ~up_prev_q;
  assign dn_rise = dn_lvl & ~dn_prev_q;

  assign up     = up_q;
  assign down   = down_q;
  assign active = active_q;

`ifdef UPDOWN_AUTOREPEAT_EN
  localparam int unsigned RptMax = max_limit(REPEAT_DELAY, REPEAT_RATE);
  localparam int unsigned RptW   = $clog2(RptMax + 1);

  logic [RptW-1:0] rpt_cnt_q;
  logic [RptW-1:0] rpt_last;
  logic            rpt_first_q;
  logic            rpt_fire;

  // First repeat waits the long delay, later ones the short rate.
  assign rpt_last = rpt_first_q ? RptW'(REPEAT_DELAY - 1) : RptW'(REPEAT_RATE - 1);
  assign rpt_fire = (rpt_cnt_q >= rpt_last);
`endif

  // Command FSM with registered pulse and active outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      active_q  <= 1'b0;
      up_prev_q <= 1'b0;
      dn_prev_q <= 1'b0;
`ifdef UPDOWN_AUTOREPEAT_EN
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
`endif
    end else begin
      up_prev_q <= up_lvl;
      dn_prev_q <= dn_lvl;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
`ifdef UPDOWN_AUTOREPEAT_EN
      if (rpt_cnt_q != RptW'(RptMax)) rpt_cnt_q <= rpt_cnt_q + 1'b1;
`endif
      unique case (state_q)
        StIdle: begin
`ifdef UPDOWN_AUTOREPEAT_EN
          // Holding the counter clear here makes it start from zero on held-state entry.
          rpt_cnt_q   <= '0;
          rpt_first_q <= 1'b1;
`endif
          if ((up_rise || dn_rise) && up_lvl && dn_lvl) begin
            state_q <= StLockout;
          end else if (up_rise) begin
            up_q     <= 1'b1;
            active_q <= 1'b1;
            state_q  <= StUpHeld;
          end else if (dn_rise) begin
            down_q   <= 1'b1;
            active_q <= 1'b1;
            state_q  <= StDownHeld;
          end
        end
        StUpHeld: begin
          if (!up_lvl) begin
            active_q <= 1'b0;
            state_q  <= StIdle;
          end
`ifdef UPDOWN_AUTOREPEAT_EN
          else if (rpt_fire) begin
            up_q        <= 1'b1;
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b0;
          end
`endif
        end
        StDownHeld: begin
          if (!dn_lvl) begin
            active_q <= 1'b0;
            state_q  <= StIdle;
          end
`ifdef UPDOWN_AUTOREPEAT_EN
          else if (rpt_fire) begin
            down_q      <= 1'b1;
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b0;
          end
`endif
        end
        StLockout: begin
          if (!up_lvl && !dn_lvl) state_q <= StIdle;
        end
        default: begin
          active_q <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/updown_cmd_gen.md
UPDOWN_CMD_GEN -- requirements
Module: updown_cmd_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, the number of consecutive stable synchronized samples needed to accept a level change (legal range >=1).
REQ-002 SHALL have parameter REPEAT_DELAY, default 16, the number of cycles from the first pulse to the first auto-repeat pulse (legal range >=2).
REQ-003 SHALL have parameter REPEAT_RATE, default 4, the number of cycles between later auto-repeat pulses (legal range >=2).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-006 SHALL have port up_btn, input, 1 bit, the raw asynchronous up button, active high.
REQ-007 SHALL have port down_btn, input, 1 bit, the raw asynchronous down button, active high.
REQ-008 SHALL have port up, output, 1 bit, a one-cycle count-up command to the downstream up/down counter.
REQ-009 SHALL have port down, output, 1 bit, a one-cycle count-down command to the downstream counter.
REQ-010 SHALL have port active, output, 1 bit, high while an accepted press is held (state UP_HELD or DOWN_HELD).

Function
REQ-011 SHALL pass each button through a two-flop synchronizer before any other logic uses it.
REQ-012 SHALL change a debounced level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any matching sample clears the run counter.
REQ-013 SHALL implement the FSM states IDLE, UP_HELD, DOWN_HELD and LOCKOUT.
REQ-014 In IDLE, when debounced up rises while debounced down is low, SHALL pulse up for 1 cycle and enter UP_HELD; the down button is handled symmetrically and enters DOWN_HELD.
REQ-015 In IDLE, when both debounced levels are high in the same cycle (both rise together, or one rises while the other is high), SHALL emit no pulse and enter LOCKOUT.
REQ-016 In UP_HELD, SHALL ignore down_btn and return to IDLE when debounced up falls; DOWN_HELD is handled symmetrically.
REQ-017 In LOCKOUT, SHALL emit no pulses and return to IDLE only when both debounced levels are low.
REQ-018 SHALL never assert up and down in the same cycle.
REQ-019 SHALL register all outputs, with no combinational path from any input to any output.
REQ-020 SHALL assert the up pulse in the cycle after clock edge 3+DEBOUNCE_CYCLES, counting the first edge that samples a raw high held stable as edge 1 (edge 7 at the defaults).
REQ-021 SHALL size each internal counter as $clog2(limit+1) bits and SHALL saturate counters so they never wrap.

Reset
REQ-022 SHALL, while reset is sampled high, force up=0, down=0, active=0, state IDLE, synchronizer flops 0, debounced levels 0 and all counters 0.
REQ-023 SHALL have reset take priority over every other event in the same cycle.
REQ-024 SHALL, after reset is released with a button still held, treat that button as a new press and emit exactly one pulse after the REQ-020 latency.

Configuration
REQ-025 With UPDOWN_AUTOREPEAT_EN defined, SHALL, in UP_HELD or DOWN_HELD, issue the first repeat pulse REPEAT_DELAY cycles after the initial pulse, then one pulse every REPEAT_RATE cycles until release; the repeat counter SHALL clear on state entry.
REQ-026 Without UPDOWN_AUTOREPEAT_EN, SHALL emit exactly one pulse per accepted press, and the repeat counters and logic SHALL be absent.

Structure
REQ-027 SHALL place the FSM state typedef and the default values of DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE in the shared package updown_pkg.
REQ-028 SHALL implement synchronizer plus debounce as the sub-module btn_debounce, instantiated once per button.

Verification (defaults DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_RATE=4)
REQ-029 SHALL cover: up_btn held 20 cycles, macro off -> up high exactly 1 cycle at edge 7, active high until debounced release, down never high.
REQ-030 SHALL cover: up_btn toggled every 2 cycles for 30 cycles (glitch burst) -> no pulse; then held stable -> exactly 1 up pulse.
REQ-031 SHALL cover: up_btn and down_btn raised on the same cycle and held 10 cycles -> no pulses, LOCKOUT; down released with up still held -> still no pulse; both released -> IDLE.
REQ-032 SHALL cover: down_btn held, then up_btn pressed during DOWN_HELD -> single down pulse only; down released with up held -> IDLE, no up pulse until up is released and pressed again.
REQ-033 SHALL cover: macro on, down_btn held 40 cycles -> down pulses at cycle offsets 0, 16, 20, 24, 28, 32, 36 relative to the first pulse.
REQ-034 SHALL cover: reset asserted for 1 cycle during UP_HELD with up_btn held -> outputs 0 the next cycle, then 1 up pulse at REQ-020 latency after reset release.
